// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder: digit width, BCD
// limits, the controller state encoding and a digit-validity helper.
package bcd_pkg;

  localparam int unsigned    DIGIT_W  = 4;
  localparam logic [3:0]     BCD_MAX  = 4'd9;
  localparam logic [4:0]     BCD_CORR = 5'd6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bcd_ctrl_state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake/operand bundle for bcd_serial_add_ctrl.
//   start, a, b, cin : request and operands (master -> slave)
//   busy, done       : status (slave -> master)
//   sum, cout, err   : registered result and non-BCD flag (slave -> master)
interface bcd_serial_add_ctrl_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);

  logic                      start;
  logic [DIGIT_W*DIGITS-1:0] a;
  logic [DIGIT_W*DIGITS-1:0] b;
  logic                      cin;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] sum;
  logic                      cout;
  logic                      err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );

endinterface

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder.
//   a, b : input digits (non-BCD values allowed, 5-bit wrap applies)
//   cin  : carry in
//   c    : result digit
//   cout : carry out
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] c,
  output logic               cout
);

  logic [DIGIT_W:0] s;
  logic [DIGIT_W:0] r;

  always_comb begin
    s = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    // Correction wraps in 5 bits, so 15+15+1 gives digit 5, carry 0.
    r = (s > {1'b0, BCD_MAX}) ? s + BCD_CORR : s;
  end

  assign {cout, c} = r;

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder that reuses one digit adder over DIGITS
// cycles, least-significant digit first, with a registered carry.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bcd_serial_add_ctrl_if (start/operands in,
//                busy/done/sum/cout/err out, all outputs registered)
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
)(
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_add_ctrl_if.slave  bus
);

  localparam int unsigned        W        = DIGIT_W * DIGITS;
  localparam int unsigned        IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIGITS - 1);

  bcd_ctrl_state_t    state;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               busy_q;
  logic               done_q;
  logic               cout_q;
  logic               err_q;

  logic [DIGIT_W-1:0] a_d;
  logic [DIGIT_W-1:0] b_d;
  logic [DIGIT_W-1:0] s_d;
  logic               c_d;
  logic               err_in;

  always_comb begin
    a_d = a_q[idx*DIGIT_W +: DIGIT_W];
    b_d = b_q[idx*DIGIT_W +: DIGIT_W];
  end

  // Evaluated on the live inputs; only consumed on the capture edge, so it
  // equals the flag of the latched copies.
  always_comb begin
    err_in = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!is_bcd(bus.a[i*DIGIT_W +: DIGIT_W]) || !is_bcd(bus.b[i*DIGIT_W +: DIGIT_W]))
        err_in = 1'b1;
    end
  end

  bcd_digit_adder u_adder (
    .a    (a_d),
    .b    (b_d),
    .cin  (carry),
    .c    (s_d),
    .cout (c_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            carry  <= bus.cin;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= err_in;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*DIGIT_W +: DIGIT_W] <= s_d;
          carry <= c_d;
          if (idx == LAST_IDX) begin
            idx    <= '0;
            cout_q <= c_d;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Multi-digit packed-BCD adder controller that sequences one shared single-digit BCD adder over an N-digit operand pair, least-significant digit first, with a registered inter-digit carry. It sits between operand registers and the display/result path, and replaces N parallel digit adders with one adder plus a digit counter. It uses a start/busy/done handshake and flags operands that contain non-BCD digits.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand; legal range 2–16.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- `b`  in  4*DIGITS  operand B, same packing
- `cin`  in  1  carry into digit 0
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle completion pulse
- `sum`  out  4*DIGITS  result, packed BCD
- `cout`  out  1  carry out of digit DIGITS-1
- `err`  out  1  some digit of a or b was >9 at the time of capture

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE, and every output resets to 0.
- **IDLE, start=1:**
  - Latch `a`, `b` into internal registers.
  - Load carry register with `cin`, set digit index to 0, clear `sum`.
  - Compute `err` from the latched digits.
  - Go to RUN.
- **IDLE, start=0:** stay in IDLE. Outputs hold their last result.
- **RUN, each cycle:**
  - Feed digit[idx] of A and B, plus the carry register, to the digit adder.
  - Write the 4-bit result into `sum` digit idx.
  - Load the carry register with the digit carry-out and increment idx.
  - When idx=DIGITS-1 is processed, go to DONE and drive `cout` from the final carry.
- **DONE:** `done`=1 for this single cycle, then go to IDLE unconditionally. `start` is ignored in RUN and DONE and is not queued.
- **Digit arithmetic:**
  - Compute s = a_d + b_d + c in 5 bits.
  - If s > 9, {carry,digit} = (s+6) mod 32; otherwise {carry,digit} = s.
  - Valid inputs max out at 9+9+1 = 19, giving digit 9 with carry 1.
- **Non-BCD digits:**
  - There is no saturation and no abort; the same rule applies with 5-bit wrap. Example: 15+15+1 = 31, and 31+6 = 37, so digit 5 with carry 0.
  - `err` is only informational and stays valid until the next accepted start.
- `sum`, `cout` and `err` hold from DONE until the next accepted start. The partially built `sum` is visible during RUN and is not guaranteed meaningful before `done`.
- Reset asserted mid-operation returns to IDLE immediately, with all outputs 0 and no `done` pulse.

## Timing
- Start accepted at edge T0. RUN occupies edges T1…T_DIGITS, with digit i written at edge T(i+1).
- `done`=1 between edge T_DIGITS and T_DIGITS+1: DIGITS+1 cycles after acceptance.
- `busy` rises after T0 and falls after T_DIGITS+1.
- `start` held high continuously gives back-to-back operations, one accepted every DIGITS+2 cycles.
- Operand inputs may change any time after T0. Only latched copies are used.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `bcd_pkg`:
  - `DIGIT_W`=4, `BCD_MAX`=9, `BCD_CORR`=6.
  - State enum `bcd_ctrl_state_t` {IDLE, RUN, DONE}.
- Sub-module `bcd_digit_adder`: combinational one-digit adder with ports a[3:0], b[3:0], cin, c[3:0], cout, implementing the digit rule above. The controller instantiates exactly one.
- Index counter width is $clog2(DIGITS).

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start for 1 cycle → `done` 5 cycles after acceptance; sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0000, cin=1 → sum=0x0000, cout=1; carry must ripple through all 4 digits.
- a=0x000F, b=0x000F, cin=1 → sum=0x0005, cout=0, err=1.
- Start accepted with 0x1111+0x2222, then start pulsed with different operands during RUN → result 0x3333; second request ignored, and only one `done`.
- `start` held high with 0x0001+0x0001 → `done` pulses every 6 cycles, sum=0x0002 each time, `busy` low for exactly 1 cycle between operations.
- `rst_n` asserted after 2 RUN cycles → sum=0, cout=0, err=0, busy=0 immediately; no `done`. After release, a new start completes normally.
